// File: rtl/afisaj_multiplexat_if.sv
// rtl/afisaj_multiplexat_if.sv - digit inputs and display outputs of the multiplexed 7-segment driver
//
// Purpose : bundles the four BCD digit inputs and the active-low display
//           outputs so the driver and its user share one port.
// Signals : MIN_BCD1, MIN_BCD0, SEC_BCD1, SEC_BCD0 - BCD digits (mm:ss)
//           an  - anode enables, active-low, an[0] = rightmost digit
//           seg - segments {g,f,e,d,c,b,a}, active-low
//           dp  - decimal point, active-low
// Modports: master - supplies digits, observes the display
//           slave  - the display driver

interface afisaj_multiplexat_if;
   logic [3:0] MIN_BCD1;
   logic [3:0] MIN_BCD0;
   logic [3:0] SEC_BCD1;
   logic [3:0] SEC_BCD0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (
      output MIN_BCD1, MIN_BCD0, SEC_BCD1, SEC_BCD0,
      input  an, seg, dp
   );

   modport slave (
      input  MIN_BCD1, MIN_BCD0, SEC_BCD1, SEC_BCD0,
      output an, seg, dp
   );
endinterface

// File: rtl/afisaj_multiplexat.sv
// rtl/afisaj_multiplexat.sv - four-digit multiplexed 7-segment driver for an mm:ss display
//
// Purpose : scans four common-anode digits, DIV clock cycles per digit.
//           The four BCD inputs are frozen into a snapshot at every frame
//           boundary (and during reset) so a frame never shows a mix of old
//           and new digits. Outputs are registered, one cycle after the
//           scan position they belong to.
// Ports   : clk   - rising-edge clock
//           reset - synchronous reset, active-high
//           bus   - afisaj_multiplexat_if.slave (digit inputs, an/seg/dp)
// Params  : DIV   - cycles each digit is lit, 2..2^20
// Macro   : AFISAJ_LEADING_ZERO_BLANK_EN - when defined, a zero minutes-tens
//           digit is blanked (all anodes off) during its slot.

module afisaj_multiplexat #(
   parameter int unsigned DIV = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   afisaj_multiplexat_if.slave   bus
);

   localparam int unsigned    CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

   localparam logic [6:0]     SEG_BLANK = 7'h7F;
   localparam logic [6:0]     SEG_DASH  = 7'h3F;

   // Scan position; the encoding doubles as the anode bit number.
   typedef enum logic [1:0] {
      SLOT_SEC0 = 2'd0,
      SLOT_SEC1 = 2'd1,
      SLOT_MIN0 = 2'd2,
      SLOT_MIN1 = 2'd3
   } slot_t;

   slot_t         idx;
   slot_t         idx_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          cnt_wrap;
   logic          frame_end;

   // Snapshot layout: {MIN_BCD1, MIN_BCD0, SEC_BCD1, SEC_BCD0}
   logic [15:0]   live;
   logic [15:0]   snap;

   logic [3:0]    digit;
   logic [3:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;

   logic [3:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q;

   assign live      = {bus.MIN_BCD1, bus.MIN_BCD0, bus.SEC_BCD1, bus.SEC_BCD0};
   assign cnt_wrap  = (cnt == CNT_LAST);
   assign frame_end = cnt_wrap && (idx == SLOT_MIN1);

   // BCD to active-low segments; non-decimal codes show a dash.
   function automatic logic [6:0] seg7_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   // ---------------------------------------------------------------
   // Scan state register (prescaler + digit index)
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         idx <= SLOT_SEC0;
      end else begin
         cnt <= cnt_next;
         idx <= idx_next;
      end
   end

   // Next-state: the prescaler wraps after DIV cycles and steps the slot.
   always_comb begin
      cnt_next = cnt + CW'(1);
      idx_next = idx;
      if (cnt_wrap) begin
         cnt_next = '0;
         case (idx)
            SLOT_SEC0: idx_next = SLOT_SEC1;
            SLOT_SEC1: idx_next = SLOT_MIN0;
            SLOT_MIN0: idx_next = SLOT_MIN1;
            SLOT_MIN1: idx_next = SLOT_SEC0;
            default:   idx_next = SLOT_SEC0;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Snapshot: reloaded on the last cycle of a frame so the new values
   // first appear together with the idx=0 slot of the next frame.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset || frame_end) begin
         snap <= live;
      end
   end

   // ---------------------------------------------------------------
   // Output decode from current slot and snapshot
   // ---------------------------------------------------------------
   always_comb begin
      digit = snap[3:0];
      case (idx)
         SLOT_SEC0: digit = snap[3:0];
         SLOT_SEC1: digit = snap[7:4];
         SLOT_MIN0: digit = snap[11:8];
         SLOT_MIN1: digit = snap[15:12];
         default:   digit = snap[3:0];
      endcase
   end

   always_comb begin
      an_next  = ~(4'b0001 << idx);
      seg_next = seg7_decode(digit);
      // The separator dot sits on the minutes-units digit.
      dp_next  = (idx != SLOT_MIN0);
`ifdef AFISAJ_LEADING_ZERO_BLANK_EN
      // Blank a leading zero by switching the anode off for its slot;
      // slot timing is untouched so the other digits keep their duty.
      if ((idx == SLOT_MIN1) && (snap[15:12] == 4'd0)) begin
         an_next  = 4'b1111;
         seg_next = SEG_BLANK;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         an_q  <= 4'b1111;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_next;
         seg_q <= seg_next;
         dp_q  <= dp_next;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;

endmodule

// File: tb/tb_afisaj_multiplexat.sv
// tb/tb_afisaj_multiplexat.sv - self-checking bench for afisaj_multiplexat (DIV=4)

module tb_afisaj_multiplexat;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   afisaj_multiplexat_if dif ();

   afisaj_multiplexat #(.DIV(DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------
   // Model: k counts edges since reset was released. The slot lit after
   // edge k is (k/DIV)%4; digits come from the values seen at the last
   // reset edge or at the last edge of the previous frame.
   // ---------------------------------------------------------------
   int         mk;
   bit         mvalid;
   logic [3:0] msnap [4];   // indexed by slot: S0, S1, M0, M1
   logic [3:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_dp;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   function automatic int slot_of(input int k);
      return (k / DIV) % 4;
   endfunction

   function automatic bit blanked(input int s, input logic [3:0] d);
`ifdef AFISAJ_LEADING_ZERO_BLANK_EN
      return (s == 3) && (d == 4'd0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] an_model(input int s, input logic [3:0] d);
      logic [3:0] a;
      a = 4'hF;
      if (!blanked(s, d)) a[s] = 1'b0;
      return a;
   endfunction

   function automatic logic [6:0] seg_model(input int s, input logic [3:0] d);
      return blanked(s, d) ? 7'h7F : seg_of(d);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         exp_an   <= 4'hF;
         exp_seg  <= 7'h7F;
         exp_dp   <= 1'b1;
         msnap[0] <= dif.SEC_BCD0;
         msnap[1] <= dif.SEC_BCD1;
         msnap[2] <= dif.MIN_BCD0;
         msnap[3] <= dif.MIN_BCD1;
         mk       <= 0;
         mvalid   <= 1'b1;
      end else if (mvalid) begin
         exp_an  <= an_model(slot_of(mk), msnap[slot_of(mk)]);
         exp_seg <= seg_model(slot_of(mk), msnap[slot_of(mk)]);
         exp_dp  <= (slot_of(mk) != 2);
         if (mk % FRAME == FRAME - 1) begin
            msnap[0] <= dif.SEC_BCD0;
            msnap[1] <= dif.SEC_BCD1;
            msnap[2] <= dif.MIN_BCD0;
            msnap[3] <= dif.MIN_BCD1;
         end
         mk <= mk + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Cycle-by-cycle compare against the model.
   always @(negedge clk) begin
      if (mvalid) begin
         check("model_an",  int'(dif.an),  int'(exp_an));
         check("model_seg", int'(dif.seg), int'(exp_seg));
         check("model_dp",  int'(dif.dp),  int'(exp_dp));
      end
   end

   // Advance to the falling edge just after edge e (counted from reset release).
   task automatic wait_edge(input int e);
      int guard;
      guard = 0;
      while (mk != e + 1 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_edge timeout waiting for edge %0d", e);
      end
   endtask

   task automatic set_digits(input logic [3:0] m1, input logic [3:0] m0,
                             input logic [3:0] s1, input logic [3:0] s0);
      dif.MIN_BCD1 = m1;
      dif.MIN_BCD0 = m0;
      dif.SEC_BCD1 = s1;
      dif.SEC_BCD0 = s0;
   endtask

   logic [3:0] an_pat  [4];
   logic [6:0] seg_pat [4];

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      mk         = 0;
      mvalid     = 1'b0;
      an_pat     = '{4'hE, 4'hD, 4'hB, 4'h7};
      seg_pat    = '{7'h19, 7'h30, 7'h24, 7'h79};
      reset      = 1'b1;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_an",  int'(dif.an),  'hF);
      check("rst_seg", int'(dif.seg), 'h7F);
      check("rst_dp",  int'(dif.dp),  1);

      // First frame after release: 4,3,2,1 with the dot on slot 2
      reset = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         wait_edge(i);
         check("frame_an",  int'(dif.an),  int'(an_pat[i / DIV]));
         check("frame_seg", int'(dif.seg), int'(seg_pat[i / DIV]));
         check("frame_dp",  int'(dif.dp),  (i / DIV == 2) ? 0 : 1);
      end

      // Change digits during the idx=1 slot of frame 1
      wait_edge(16);
      check("f1_s0_seg", int'(dif.seg), 'h19);
      wait_edge(20);
      set_digits(4'd0, 4'd2, 4'hC, 4'd7);
      wait_edge(24);
      check("f1_min0_unchanged", int'(dif.seg), 'h24);
      wait_edge(28);
      check("f1_min1_unchanged", int'(dif.seg), 'h79);
      wait_edge(32);
      check("f2_s0_an",  int'(dif.an),  'hE);
      check("f2_s0_seg", int'(dif.seg), 'h78);
      wait_edge(36);
      check("f2_dash_an",  int'(dif.an),  'hD);
      check("f2_dash_seg", int'(dif.seg), 'h3F);
      for (int i = 44; i < 48; i++) begin
         wait_edge(i);
`ifdef AFISAJ_LEADING_ZERO_BLANK_EN
         check("lz_an",  int'(dif.an),  'hF);
         check("lz_seg", int'(dif.seg), 'h7F);
`else
         check("lz_an",  int'(dif.an),  'h7);
         check("lz_seg", int'(dif.seg), 'h40);
`endif
         check("lz_dp", int'(dif.dp), 1);
      end

      // One-cycle reset pulse inside the idx=2 slot of frame 3
      wait_edge(56);
      reset = 1'b1;
      @(negedge clk);
      check("pulse_an",  int'(dif.an),  'hF);
      check("pulse_seg", int'(dif.seg), 'h7F);
      reset = 1'b0;
      wait_edge(0);
      check("restart_an",  int'(dif.an),  'hE);
      check("restart_seg", int'(dif.seg), 'h78);
      wait_edge(4);
      check("restart_slot1_an", int'(dif.an), 'hD);

      // Remaining decode codes, left to the model
      wait_edge(6);
      set_digits(4'd9, 4'd8, 4'd5, 4'd6);
      wait_edge(3 * FRAME);
      set_digits(4'hA, 4'hF, 4'd0, 4'd1);
      wait_edge(4 * FRAME + 5);
      set_digits(4'd0, 4'hB, 4'hE, 4'hD);
      wait_edge(6 * FRAME);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
